// File: rtl/rf_writeback_arbiter_if.sv
// rf_writeback_arbiter_if: the arbiter's result, handshake, query and
// write-port signals.
//   master : the CPU side. It drives the ALU result, the memory result
//            offer and the hazard query, and observes everything else.
//   slave  : the arbiter.
//   fifo_count is $clog2(DEPTH)+1 bits wide so it can hold 0..DEPTH.
interface rf_writeback_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             alu_valid;
  logic [5:0]       alu_addr;
  logic [31:0]      alu_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [5:0]       mem_addr;
  logic [31:0]      mem_data;
  logic             alu_stall;
  logic             alu_drop;
  logic [5:0]       query_addr;
  logic             query_pending;
  logic [CNT_W-1:0] fifo_count;
  logic             rf_write_enable;
  logic [5:0]       rf_write_addr;
  logic [31:0]      rf_write_data;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, query_addr,
    input  mem_ready, alu_stall, alu_drop, query_pending, fifo_count,
           rf_write_enable, rf_write_addr, rf_write_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, query_addr,
    output mem_ready, alu_stall, alu_drop, query_pending, fifo_count,
           rf_write_enable, rf_write_addr, rf_write_data
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges ALU results (no backpressure) and memory
// results (valid/ready) onto the single register-file write port.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : rf_writeback_arbiter_if.slave, which carries:
//           - the ALU result and the memory result handshake
//           - alu_stall and the sticky alu_drop flag
//           - the pending-write query
//           - fifo_count
//           - the registered write port rf_write_*
// Memory results wait in an in-order circular FIFO while the ALU holds the
// port. A wait counter forces the FIFO head through for one cycle (alu_stall)
// after STARVE_LIMIT lost cycles.
module rf_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  reset,
  rf_writeback_arbiter_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [5:0]        fifo_addr_q [DEPTH];
  logic [31:0]       fifo_data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              drop_q, drop_d;
  logic              we_q, we_d;
  logic [5:0]        waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              empty, accept, stall, push, pop, pending;

  assign empty  = (count_q == '0);
  // Ready uses the occupancy at the start of the cycle, so a full FIFO
  // refuses even when its head is popped in the same cycle.
  assign bus.mem_ready = !reset && (count_q < CNT_W'(DEPTH));
  assign accept = bus.mem_valid && bus.mem_ready;
  assign stall  = (wait_q == WAIT_W'(STARVE_LIMIT)) && !empty;

  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    drop_d  = drop_q;
    if (stall) begin
      // Forced retirement. Any ALU result in this cycle is lost.
      pop     = 1'b1;
      we_d    = 1'b1;
      waddr_d = fifo_addr_q[rd_ptr_q];
      wdata_d = fifo_data_q[rd_ptr_q];
      push    = accept;
      if (bus.alu_valid) drop_d = 1'b1;
    end else if (bus.alu_valid) begin
      we_d    = 1'b1;
      waddr_d = bus.alu_addr;
      wdata_d = bus.alu_data;
      push    = accept;
    end else if (!empty) begin
      pop     = 1'b1;
      we_d    = 1'b1;
      waddr_d = fifo_addr_q[rd_ptr_q];
      wdata_d = fifo_data_q[rd_ptr_q];
      push    = accept;
    end else if (accept) begin
      // Empty FIFO and an idle port: bypass the FIFO.
      we_d    = 1'b1;
      waddr_d = bus.mem_addr;
      wdata_d = bus.mem_data;
    end

    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    if (pop || empty)                          wait_d = '0;
    else if (wait_q != WAIT_W'(STARVE_LIMIT))  wait_d = wait_q + 1'b1;
    else                                       wait_d = wait_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      drop_q   <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      drop_q   <= drop_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Entry storage needs no reset because count_q marks which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.mem_addr;
      fifo_data_q[wr_ptr_q] <= bus.mem_data;
    end
  end

  // A write counts as pending while it is queued, or while it sits in the
  // write register that the regfile has not yet absorbed.
  always_comb begin
    pending = we_q && (waddr_q == bus.query_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) &&
          (fifo_addr_q[rd_ptr_q + PTR_W'(i)] == bus.query_addr))
        pending = 1'b1;
    end
  end

  assign bus.query_pending   = pending;
  assign bus.alu_stall       = stall;
  assign bus.alu_drop        = drop_q;
  assign bus.fifo_count      = count_q;
  assign bus.rf_write_enable = we_q;
  assign bus.rf_write_addr   = waddr_q;
  assign bus.rf_write_data   = wdata_q;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed test of rf_writeback_arbiter with
// DEPTH=4 and STARVE_LIMIT=4. Expected values are worked out by hand from
// the arbitration and starvation rules. A small regfile array absorbs the
// write port so that read-after-write can be checked.
module tb_rf_writeback_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] rf_mem [64];

  always #5 clk = ~clk;

  rf_writeback_arbiter_if #(.DEPTH(4)) bus ();

  rf_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clk)
    if (bus.rf_write_enable) rf_mem[bus.rf_write_addr] <= bus.rf_write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [5:0] a, input logic [31:0] d);
    bus.alu_valid = v; bus.alu_addr = a; bus.alu_data = d;
  endtask

  task automatic mem(input logic v, input logic [5:0] a, input logic [31:0] d);
    bus.mem_valid = v; bus.mem_addr = a; bus.mem_data = d;
  endtask

  task automatic wport(input string tag, input logic we, input logic [5:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(bus.rf_write_enable), 32'(we));
    if (we) begin
      chk({tag, "_addr"}, 32'(bus.rf_write_addr), 32'(a));
      chk({tag, "_data"}, bus.rf_write_data, d);
    end
  endtask

  initial begin
    reset = 1'b1;
    alu(0, 0, 0);
    mem(0, 0, 0);
    bus.query_addr = 6'd0;
    #1;
    chk("rst_we",    32'(bus.rf_write_enable), 0);
    chk("rst_addr",  32'(bus.rf_write_addr), 0);
    chk("rst_data",  bus.rf_write_data, 0);
    chk("rst_cnt",   32'(bus.fifo_count), 0);
    chk("rst_ready", 32'(bus.mem_ready), 0);
    chk("rst_stall", 32'(bus.alu_stall), 0);
    chk("rst_drop",  32'(bus.alu_drop), 0);
    step(); step();
    reset = 1'b0;
    #1;
    chk("rel_ready", 32'(bus.mem_ready), 1);

    // ALU only: the result shows on the port one cycle later.
    alu(1, 6'd5, 32'h1234);
    step();
    alu(0, 0, 0);
    wport("alu", 1, 6'd5, 32'h1234);
    step();
    chk("alu_idle_we", 32'(bus.rf_write_enable), 0);
    chk("alu_hold_addr", 32'(bus.rf_write_addr), 5);
    chk("alu_rf5", rf_mem[5], 32'h1234);

    // Bypass: an empty FIFO and no ALU result.
    mem(1, 6'd7, 32'hDEAD);
    #1;
    chk("byp_ready", 32'(bus.mem_ready), 1);
    step();
    mem(0, 0, 0);
    wport("byp", 1, 6'd7, 32'hDEAD);
    chk("byp_cnt", 32'(bus.fifo_count), 0);
    step();
    chk("byp_idle", 32'(bus.rf_write_enable), 0);

    // Conflict, order and drop: the ALU is busy every cycle.
    alu(1, 6'd20, 32'd100); mem(1, 6'd1, 32'h11); step();      // wait 0
    wport("cf0", 1, 6'd20, 32'd100);
    chk("cf0_cnt", 32'(bus.fifo_count), 1);
    alu(1, 6'd21, 32'd101); mem(1, 6'd2, 32'h22); step();      // wait 1
    alu(1, 6'd22, 32'd102); mem(1, 6'd3, 32'h33); step();      // wait 2
    chk("cf2_cnt", 32'(bus.fifo_count), 3);
    alu(1, 6'd23, 32'd103); mem(0, 0, 0); step();              // wait 3
    chk("cf3_stall", 32'(bus.alu_stall), 0);
    chk("cf3_cnt", 32'(bus.fifo_count), 3);
    alu(1, 6'd24, 32'd104); step();                            // wait 4
    wport("cf4", 1, 6'd24, 32'd104);
    chk("cf4_stall", 32'(bus.alu_stall), 1);
    chk("cf4_drop_pre", 32'(bus.alu_drop), 0);
    alu(1, 6'd25, 32'd105); step();                            // ALU result lost
    wport("cf5_head", 1, 6'd1, 32'h11);
    chk("cf5_drop", 32'(bus.alu_drop), 1);
    chk("cf5_cnt", 32'(bus.fifo_count), 2);
    chk("cf5_stall", 32'(bus.alu_stall), 0);
    alu(0, 0, 0); step();
    wport("cf6", 1, 6'd2, 32'h22);
    step();
    wport("cf7", 1, 6'd3, 32'h33);
    chk("cf7_cnt", 32'(bus.fifo_count), 0);
    step();
    chk("cf8_idle", 32'(bus.rf_write_enable), 0);
    chk("cf8_drop_sticky", 32'(bus.alu_drop), 1);

    // Full: four pushes while the ALU is busy, then hold mem_valid.
    alu(1, 6'd30, 32'd300);
    mem(1, 6'd40, 32'h40); step();
    mem(1, 6'd41, 32'h41); step();
    mem(1, 6'd42, 32'h42); step();
    mem(1, 6'd43, 32'h43); step();                             // wait 3
    chk("full_cnt", 32'(bus.fifo_count), 4);
    mem(1, 6'd44, 32'h44);
    #1;
    chk("full_ready", 32'(bus.mem_ready), 0);
    step();                                                    // wait 4
    chk("full_stall", 32'(bus.alu_stall), 1);
    chk("full_ready2", 32'(bus.mem_ready), 0);
    alu(0, 0, 0); step();                                      // pop, no push
    wport("full_pop", 1, 6'd40, 32'h40);
    chk("full_nopush_cnt", 32'(bus.fifo_count), 3);
    mem(0, 0, 0); step();
    wport("full_d1", 1, 6'd41, 32'h41);
    step();
    wport("full_d2", 1, 6'd42, 32'h42);
    step();
    wport("full_d3", 1, 6'd43, 32'h43);
    chk("full_cnt0", 32'(bus.fifo_count), 0);
    step();
    chk("full_idle", 32'(bus.rf_write_enable), 0);

    // Query: address 9 is queued, then it retires through the write register.
    alu(1, 6'd50, 32'd500); mem(1, 6'd9, 32'h99); step();
    alu(0, 0, 0); mem(0, 0, 0);
    bus.query_addr = 6'd9;  #1;
    chk("q9_fifo", 32'(bus.query_pending), 1);
    bus.query_addr = 6'd10; #1;
    chk("q10", 32'(bus.query_pending), 0);
    bus.query_addr = 6'd50; #1;
    chk("q50_wreg", 32'(bus.query_pending), 1);
    bus.query_addr = 6'd9;
    step();
    wport("q_ret", 1, 6'd9, 32'h99);
    chk("q9_wreg", 32'(bus.query_pending), 1);
    step();
    chk("q9_gone", 32'(bus.query_pending), 0);

    // Reset asserted mid-burst while 3 entries are queued.
    alu(1, 6'd60, 32'd600);
    mem(1, 6'd61, 32'h61); step();
    mem(1, 6'd62, 32'h62); step();
    mem(1, 6'd63, 32'h63); step();
    chk("mr_cnt3", 32'(bus.fifo_count), 3);
    mem(1, 6'd7, 32'h77);
    reset = 1'b1;
    #1;
    chk("mr_we",    32'(bus.rf_write_enable), 0);
    chk("mr_addr",  32'(bus.rf_write_addr), 0);
    chk("mr_data",  bus.rf_write_data, 0);
    chk("mr_cnt",   32'(bus.fifo_count), 0);
    chk("mr_ready", 32'(bus.mem_ready), 0);
    chk("mr_stall", 32'(bus.alu_stall), 0);
    chk("mr_drop",  32'(bus.alu_drop), 0);
    step();
    chk("mr_hold_we", 32'(bus.rf_write_enable), 0);
    reset = 1'b0;
    alu(0, 0, 0); mem(0, 0, 0);
    #1;
    chk("mr_rel_ready", 32'(bus.mem_ready), 1);
    step();
    chk("mr_nostale", 32'(bus.rf_write_enable), 0);
    chk("mr_cnt_after", 32'(bus.fifo_count), 0);
    step();
    chk("mr_nostale2", 32'(bus.rf_write_enable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
